fsm_step_4: RTL and testbench
=============================

# fsm_step_4

Memory-access stage controller for the multi-cycle CPU, sitting directly upstream of the write-back controller. It takes the instruction opcode, ALU result and store data from the execute step, and runs the data-memory request/acknowledge handshake for `lw` (100011) and `sw` (101011). It forwards the opcode, loaded data and ALU result to step 5 with a one-cycle valid pulse. While a memory access is outstanding it stalls upstream.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 16: cycles `mem_req` may stay high without `mem_ack` before abort. Used only with `MEM_TIMEOUT_EN`. Legal range 1..255.

Ports:
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `valid_in` input 1: upstream presents an instruction this cycle.
- `opcode_step_4` input 6: opcode of the presented instruction.
- `alu_result_step_4` input 32: ALU result; this is the memory address for `lw`/`sw`.
- `rt_data_step_4` input 32: store data for `sw`.
- `stall` output 1: upstream must hold its inputs stable.
- `mem_req` output 1: data-memory request.
- `mem_we` output 1: write enable; 1 for `sw`, 0 for `lw`.
- `mem_addr` output 32: memory address.
- `mem_wdata` output 32: store data.
- `mem_rdata` input 32: load data; valid when `mem_ack` is high.
- `mem_ack` input 1: memory completes the access this cycle.
- `valid_out` output 1: one-cycle pulse; step-5 outputs are updated.
- `opcode_step_5` output 6: opcode forwarded to `fsm_step_5`.
- `mem_data_step_5` output 32: loaded word.
- `alu_result_step_5` output 32: forwarded ALU result.
- `mem_error` output 1: sticky timeout flag.

## Operation
- States: IDLE and WAIT.
- IDLE, `valid_in`=0: no change; `valid_out`=0.
- IDLE, `valid_in`=1, non-memory opcode:
  - `opcode_step_5` and `alu_result_step_5` load at the next edge.
  - `valid_out`=1 for the next cycle.
  - State stays IDLE.
- IDLE, `valid_in`=1, `lw`/`sw`:
  - Latch the address, the data, and `mem_we` (1 for `sw`).
  - Assert `mem_req` from the next edge; go to WAIT.
- WAIT:
  - `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are held constant.
  - `stall`=1; `valid_in` and the data inputs are ignored.
- WAIT, `mem_ack`=1 sampled at an edge:
  - `mem_req` falls and the state returns to IDLE.
  - `opcode_step_5` and `alu_result_step_5` load.
  - For `lw` only, `mem_data_step_5` loads `mem_rdata`; for `sw` it holds its value.
  - `valid_out`=1 for one cycle.
- `mem_ack` while not in WAIT is ignored.
- `stall` is combinational: 1 exactly when the state is WAIT.
- Step-5 outputs hold their value between `valid_out` pulses.
- Reset values:
  - State IDLE.
  - `mem_req`, `mem_we`, `valid_out` and `mem_error` are 0.
  - `opcode_step_5`=6'b000000, which step 5 treats as non-load.
  - All 32-bit outputs are 0.
- Reset asserted during WAIT: the request is abandoned and `mem_req`=0 after that edge. An acknowledge arriving later is ignored.

## Timing
- Non-memory instruction accepted at edge N: `valid_out` is high in cycle N+1. Throughput is 1 per cycle.
- Memory instruction accepted at edge N:
  - `mem_req` is high from cycle N+1.
  - If `mem_ack` is sampled at edge N+k (k≥1), `valid_out` is high in cycle N+k+1 and `mem_req` is low in cycle N+k+1.
- The next instruction can be accepted at edge N+k+1. Minimum memory-op latency is 2 cycles.
- `mem_ack` combinational in the same cycle `mem_req` rises is legal; that is the k=1 case.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entry to WAIT and increments each WAIT cycle without `mem_ack`.
  - When the count reaches `TIMEOUT_CYCLES`:
    - `mem_req` drops and the state returns to IDLE.
    - `mem_error` sets, sticky until `rst`.
    - `valid_out` pulses with `mem_data_step_5`=0, even for `lw`.
  - `mem_ack` on the expiry cycle wins: the access is a normal completion and there is no error.
- `MEM_TIMEOUT_EN` undefined: WAIT lasts indefinitely, no counter is built, and `mem_error` is tied to 0.

## Test plan
- Reset, then `add` opcode 000000 with `valid_in` → `valid_out` pulses the next cycle, `opcode_step_5`=000000, `mem_req` stays 0.
- `lw` at address 0x0000_0010; `mem_ack` 3 cycles after `mem_req` with `mem_rdata`=0xCAFE_F00D → `stall` is high for 3 cycles, then `valid_out` pulses with `opcode_step_5`=100011 and `mem_data_step_5`=0xCAFE_F00D.
- `sw` at address 0x20, data 0x1234_5678; `mem_ack` after 1 cycle → `mem_we`=1 and `mem_wdata`=0x1234_5678 while requesting, `mem_data_step_5` unchanged, `valid_out` pulses.
- `rst` pulsed during WAIT, then `mem_ack` → `mem_req`=0 after the reset edge, no `valid_out`, all outputs at their reset values.
- `lw` immediately followed by `add`, with `valid_in` held → the `add` is accepted the cycle after the ack, and `valid_out` pulses on consecutive instructions in order.
- `MEM_TIMEOUT_EN` with `TIMEOUT_CYCLES`=4 and no ack → `mem_req` drops after 4 cycles, `mem_error`=1, `valid_out` pulses with data 0; a second case with ack on cycle 4 → no error.

Source files
------------

// File: rtl/fsm_step_4.sv
// fsm_step_4 -- memory-access stage controller of the multi-cycle CPU.
//
// Accepts one instruction per cycle from the execute step. Non-memory
// instructions are forwarded to step 5 on the next cycle. lw (100011) and
// sw (101011) run a req/ack handshake with data memory, stalling upstream
// until the access completes, and are then forwarded to step 5.
//
// Optional feature: define MEM_TIMEOUT_EN to abort a request that stays
// unacknowledged for TIMEOUT_CYCLES cycles (sets sticky mem_error).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   valid_in                 upstream presents an instruction
//   opcode_step_4            opcode of presented instruction
//   alu_result_step_4        ALU result / memory address
//   rt_data_step_4           store data
//   stall                    upstream must hold (state is WAIT)
//   mem_req/mem_we           memory request / write enable
//   mem_addr/mem_wdata       memory address / store data
//   mem_rdata/mem_ack        load data / access complete
//   valid_out                one-cycle pulse, step-5 outputs updated
//   opcode_step_5            forwarded opcode
//   mem_data_step_5          loaded word
//   alu_result_step_5        forwarded ALU result
//   mem_error                sticky timeout flag (0 without MEM_TIMEOUT_EN)

module fsm_step_4 #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [5:0]  opcode_step_4,
    input  logic [31:0] alu_result_step_4,
    input  logic [31:0] rt_data_step_4,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        valid_out,
    output logic [5:0]  opcode_step_5,
    output logic [31:0] mem_data_step_5,
    output logic [31:0] alu_result_step_5,
    output logic        mem_error
);

    localparam logic [5:0] OP_LW = 6'b100011;
    localparam logic [5:0] OP_SW = 6'b101011;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t state;
    logic   is_mem_op;

    assign is_mem_op = (opcode_step_4 == OP_LW) || (opcode_step_4 == OP_SW);
    assign stall     = (state == S_WAIT);

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] tmo_cnt;
    logic       tmo_expire;

    // Expiry is the WAIT cycle whose edge would bring the count to
    // TIMEOUT_CYCLES; an ack on that same edge still takes priority.
    assign tmo_expire = (tmo_cnt == TMO_LAST);
`else
    logic [7:0] unused_tmo_cfg;

    assign unused_tmo_cfg = 8'(TIMEOUT_CYCLES);
    assign mem_error      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= S_IDLE;
            mem_req           <= 1'b0;
            mem_we            <= 1'b0;
            mem_addr          <= '0;
            mem_wdata         <= '0;
            valid_out         <= 1'b0;
            opcode_step_5     <= '0;
            mem_data_step_5   <= '0;
            alu_result_step_5 <= '0;
`ifdef MEM_TIMEOUT_EN
            tmo_cnt           <= '0;
            mem_error         <= 1'b0;
`endif
        end else begin
            valid_out <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (valid_in) begin
                        if (is_mem_op) begin
                            mem_req   <= 1'b1;
                            mem_we    <= (opcode_step_4 == OP_SW);
                            mem_addr  <= alu_result_step_4;
                            mem_wdata <= rt_data_step_4;
                            state     <= S_WAIT;
`ifdef MEM_TIMEOUT_EN
                            tmo_cnt   <= '0;
`endif
                        end else begin
                            opcode_step_5     <= opcode_step_4;
                            alu_result_step_5 <= alu_result_step_4;
                            valid_out         <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    // The pending opcode is recovered from mem_we and the
                    // ALU result from the latched address, so no extra
                    // copy of the instruction is kept while waiting.
                    if (mem_ack) begin
                        mem_req           <= 1'b0;
                        state             <= S_IDLE;
                        opcode_step_5     <= mem_we ? OP_SW : OP_LW;
                        alu_result_step_5 <= mem_addr;
                        if (!mem_we) begin
                            mem_data_step_5 <= mem_rdata;
                        end
                        valid_out         <= 1'b1;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (tmo_expire) begin
                        mem_req           <= 1'b0;
                        state             <= S_IDLE;
                        opcode_step_5     <= mem_we ? OP_SW : OP_LW;
                        alu_result_step_5 <= mem_addr;
                        mem_data_step_5   <= '0;
                        valid_out         <= 1'b1;
                        mem_error         <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
`endif
                end
                default: begin
                    state   <= S_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_step_4.sv
module tb_fsm_step_4;

    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] SW  = 6'b101011;
    localparam logic [5:0] ADD = 6'b000000;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [5:0]  opcode_step_4;
    logic [31:0] alu_result_step_4;
    logic [31:0] rt_data_step_4;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        valid_out;
    logic [5:0]  opcode_step_5;
    logic [31:0] mem_data_step_5;
    logic [31:0] alu_result_step_5;
    logic        mem_error;

    always #5 clk = ~clk;

    fsm_step_4 #(.TIMEOUT_CYCLES(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .valid_in          (valid_in),
        .opcode_step_4     (opcode_step_4),
        .alu_result_step_4 (alu_result_step_4),
        .rt_data_step_4    (rt_data_step_4),
        .stall             (stall),
        .mem_req           (mem_req),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_rdata         (mem_rdata),
        .mem_ack           (mem_ack),
        .valid_out         (valid_out),
        .opcode_step_5     (opcode_step_5),
        .mem_data_step_5   (mem_data_step_5),
        .alu_result_step_5 (alu_result_step_5),
        .mem_error         (mem_error)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vi, input logic [5:0] op, input logic [31:0] alu,
                         input logic [31:0] rt, input logic ack, input logic [31:0] rdata);
        valid_in          = vi;
        opcode_step_4     = op;
        alu_result_step_4 = alu;
        rt_data_step_4    = rt;
        mem_ack           = ack;
        mem_rdata         = rdata;
    endtask

    typedef struct {
        logic        vi;
        logic [5:0]  op;
        logic [31:0] alu;
        logic [31:0] rt;
        logic        ack;
        logic [31:0] rdata;
        logic        vo;
        logic        stall;
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [5:0]  op5;
        logic [31:0] alu5;
        logic [31:0] d5;
    } vec_t;

    function automatic vec_t mk(input logic vi, input logic [5:0] op, input logic [31:0] alu,
                                input logic [31:0] rt, input logic ack, input logic [31:0] rdata,
                                input logic vo, input logic st, input logic req, input logic we,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [5:0] op5, input logic [31:0] alu5,
                                input logic [31:0] d5);
        vec_t v;
        v.vi = vi; v.op = op; v.alu = alu; v.rt = rt; v.ack = ack; v.rdata = rdata;
        v.vo = vo; v.stall = st; v.req = req; v.we = we; v.addr = addr; v.wdata = wdata;
        v.op5 = op5; v.alu5 = alu5; v.d5 = d5;
        return v;
    endfunction

    vec_t vecs[12];

    // Transaction-level reference state for the random section.
    logic        busy;
    int unsigned wait_left;
    logic [5:0]  p_op;
    logic [31:0] p_addr, p_wdata;
    logic        m_vo;
    logic [5:0]  m_op5;
    logic [31:0] m_alu5, m_d5;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        drive(0, ADD, 0, 0, 0, 0);
        step();
        step();
        chk("rst_mem_req",   mem_req, 0);
        chk("rst_mem_we",    mem_we, 0);
        chk("rst_valid_out", valid_out, 0);
        chk("rst_stall",     stall, 0);
        chk("rst_mem_error", mem_error, 0);
        chk("rst_op5",       opcode_step_5, 0);
        chk("rst_d5",        mem_data_step_5, 0);
        chk("rst_alu5",      alu_result_step_5, 0);
        chk("rst_addr",      mem_addr, 0);
        chk("rst_wdata",     mem_wdata, 0);
        rst = 1'b0;

        // ---------------- directed table ----------------
        vecs[0]  = mk(1, ADD, 32'h55, 0, 0, 0,                    1, 0, 0, 0, 0, 0, ADD, 32'h55, 0);
        vecs[1]  = mk(0, ADD, 32'h66, 0, 0, 0,                    0, 0, 0, 0, 0, 0, ADD, 32'h55, 0);
        vecs[2]  = mk(1, LW, 32'h10, 32'hAAAA, 0, 0,              0, 1, 1, 0, 32'h10, 32'hAAAA, ADD, 32'h55, 0);
        vecs[3]  = mk(1, ADD, 32'h77, 32'h1, 0, 0,                0, 1, 1, 0, 32'h10, 32'hAAAA, ADD, 32'h55, 0);
        vecs[4]  = mk(1, SW, 32'h88, 32'h2, 0, 0,                 0, 1, 1, 0, 32'h10, 32'hAAAA, ADD, 32'h55, 0);
        vecs[5]  = mk(0, ADD, 0, 0, 1, 32'hCAFEF00D,              1, 0, 0, 0, 0, 0, LW, 32'h10, 32'hCAFEF00D);
        vecs[6]  = mk(1, SW, 32'h20, 32'h12345678, 0, 0,          0, 1, 1, 1, 32'h20, 32'h12345678, LW, 32'h10, 32'hCAFEF00D);
        vecs[7]  = mk(1, ADD, 32'h99, 0, 1, 32'hBBBB,             1, 0, 0, 0, 0, 0, SW, 32'h20, 32'hCAFEF00D);
        vecs[8]  = mk(1, LW, 32'h30, 32'h5, 0, 0,                 0, 1, 1, 0, 32'h30, 32'h5, SW, 32'h20, 32'hCAFEF00D);
        vecs[9]  = mk(1, ADD, 32'h99, 0, 1, 32'hDEADBEEF,         1, 0, 0, 0, 0, 0, LW, 32'h30, 32'hDEADBEEF);
        vecs[10] = mk(1, ADD, 32'h99, 0, 0, 0,                    1, 0, 0, 0, 0, 0, ADD, 32'h99, 32'hDEADBEEF);
        vecs[11] = mk(0, ADD, 0, 0, 1, 32'h1,                     0, 0, 0, 0, 0, 0, ADD, 32'h99, 32'hDEADBEEF);

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].vi, vecs[i].op, vecs[i].alu, vecs[i].rt, vecs[i].ack, vecs[i].rdata);
            step();
            chk($sformatf("vec%0d_valid_out", i), valid_out, vecs[i].vo);
            chk($sformatf("vec%0d_stall", i), stall, vecs[i].stall);
            chk($sformatf("vec%0d_mem_req", i), mem_req, vecs[i].req);
            chk($sformatf("vec%0d_op5", i), opcode_step_5, vecs[i].op5);
            chk($sformatf("vec%0d_alu5", i), alu_result_step_5, vecs[i].alu5);
            chk($sformatf("vec%0d_d5", i), mem_data_step_5, vecs[i].d5);
            if (vecs[i].req) begin
                chk($sformatf("vec%0d_we", i), mem_we, vecs[i].we);
                chk($sformatf("vec%0d_addr", i), mem_addr, vecs[i].addr);
                chk($sformatf("vec%0d_wdata", i), mem_wdata, vecs[i].wdata);
            end
        end

        // ---------------- reset during WAIT ----------------
        drive(1, LW, 32'h40, 32'h77, 0, 0);
        step();
        drive(0, ADD, 0, 0, 0, 0);
        chk("rw_req_before", mem_req, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rw_req",   mem_req, 0);
        chk("rw_we",    mem_we, 0);
        chk("rw_addr",  mem_addr, 0);
        chk("rw_wdata", mem_wdata, 0);
        chk("rw_vo",    valid_out, 0);
        chk("rw_op5",   opcode_step_5, 0);
        chk("rw_alu5",  alu_result_step_5, 0);
        chk("rw_d5",    mem_data_step_5, 0);
        drive(0, ADD, 0, 0, 1, 32'hFFFF);
        step();
        drive(0, ADD, 0, 0, 0, 0);
        chk("rw_late_ack_vo",    valid_out, 0);
        chk("rw_late_ack_req",   mem_req, 0);
        chk("rw_late_ack_stall", stall, 0);
        chk("rw_late_ack_d5",    mem_data_step_5, 0);
        step();
        chk("rw_after_vo", valid_out, 0);

        // ---------------- unacknowledged request ----------------
        drive(1, LW, 32'h60, 0, 0, 0);
        step();
        drive(0, ADD, 0, 0, 1, 32'h5A5A5A5A);
        step();
        drive(0, ADD, 0, 0, 0, 0);
        chk("pre_d5", mem_data_step_5, 32'h5A5A5A5A);
        drive(1, LW, 32'h50, 0, 0, 0);
        step();
        drive(0, ADD, 0, 0, 0, 0);
`ifdef MEM_TIMEOUT_EN
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("tmo_req_c%0d", c), mem_req, 1);
            chk($sformatf("tmo_err_c%0d", c), mem_error, 0);
            step();
        end
        chk("tmo_req_drop", mem_req, 0);
        chk("tmo_stall",    stall, 0);
        chk("tmo_vo",       valid_out, 1);
        chk("tmo_err",      mem_error, 1);
        chk("tmo_d5",       mem_data_step_5, 0);
        chk("tmo_op5",      opcode_step_5, LW);
        step();
        chk("tmo_vo_once",  valid_out, 0);
        chk("tmo_sticky",   mem_error, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("tmo_err_clr",  mem_error, 0);
        drive(1, LW, 32'h70, 0, 0, 0);
        step();
        drive(0, ADD, 0, 0, 0, 0);
        for (int c = 1; c <= 3; c++) begin
            chk($sformatf("tmo2_req_c%0d", c), mem_req, 1);
            step();
        end
        drive(0, ADD, 0, 0, 1, 32'h0BADCAFE);
        step();
        drive(0, ADD, 0, 0, 0, 0);
        chk("tmo2_vo",  valid_out, 1);
        chk("tmo2_err", mem_error, 0);
        chk("tmo2_d5",  mem_data_step_5, 32'h0BADCAFE);
        chk("tmo2_req", mem_req, 0);
`else
        for (int c = 1; c <= 10; c++) begin
            chk($sformatf("hold_req_c%0d", c), mem_req, 1);
            chk($sformatf("hold_stall_c%0d", c), stall, 1);
            chk($sformatf("hold_err_c%0d", c), mem_error, 0);
            step();
        end
        drive(0, ADD, 0, 0, 1, 32'h0BADCAFE);
        step();
        drive(0, ADD, 0, 0, 0, 0);
        chk("hold_vo",  valid_out, 1);
        chk("hold_d5",  mem_data_step_5, 32'h0BADCAFE);
        chk("hold_req", mem_req, 0);
`endif

        // ---------------- random vs transaction model ----------------
        rst = 1'b1;
        step();
        rst = 1'b0;
        busy = 1'b0; wait_left = 0; p_op = '0; p_addr = '0; p_wdata = '0;
        m_vo = 1'b0; m_op5 = '0; m_alu5 = '0; m_d5 = '0;
        for (int n = 0; n < 2000; n++) begin
            chk("rnd_valid_out", valid_out, m_vo);
            chk("rnd_op5",       opcode_step_5, m_op5);
            chk("rnd_alu5",      alu_result_step_5, m_alu5);
            chk("rnd_d5",        mem_data_step_5, m_d5);
            chk("rnd_stall",     stall, busy);
            chk("rnd_mem_req",   mem_req, busy);
            chk("rnd_mem_error", mem_error, 0);
            if (busy) begin
                chk("rnd_addr",  mem_addr, p_addr);
                chk("rnd_we",    mem_we, p_op == SW);
                chk("rnd_wdata", mem_wdata, p_wdata);
            end

            m_vo = 1'b0;
            if (busy) begin
                // Inputs while waiting are junk that must be ignored.
                drive(1'($urandom), 6'($urandom), $urandom, $urandom, 0, $urandom);
                if (wait_left == 0) begin
                    mem_ack = 1'b1;
                    m_vo    = 1'b1;
                    m_op5   = p_op;
                    m_alu5  = p_addr;
                    if (p_op == LW) m_d5 = mem_rdata;
                    busy = 1'b0;
                end else begin
                    wait_left--;
                end
            end else begin
                logic [5:0] op;
                case ($urandom_range(3))
                    0:       op = LW;
                    1:       op = SW;
                    2:       op = ADD;
                    default: op = 6'($urandom);
                endcase
                drive($urandom_range(3) != 0, op, $urandom, $urandom, 1'($urandom), $urandom);
                if (valid_in) begin
                    if (op == LW || op == SW) begin
                        busy      = 1'b1;
                        p_op      = op;
                        p_addr    = alu_result_step_4;
                        p_wdata   = rt_data_step_4;
                        wait_left = $urandom_range(3);
                    end else begin
                        m_vo   = 1'b1;
                        m_op5  = op;
                        m_alu5 = alu_result_step_4;
                    end
                end
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
